// File: rtl/rle_encoder.sv
// rtl/rle_encoder.sv - byte-stream run-length encoder emitting LSB-aligned variable-length codes
module rle_encoder #(
    parameter int CNT_W = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    input  logic        byte_last,
    output logic        byte_ready,
    output logic [63:0] code_out,
    output logic [6:0]  code_bits,
    output logic        code_valid,
    output logic        msg_fin
);

    // len must hold MAXRUN = 2^CNT_W + 1, which fits in CNT_W + 1 bits for CNT_W >= 1
    localparam int                LEN_W  = CNT_W + 1;
    localparam logic [LEN_W-1:0]  MAXRUN = LEN_W'((1 << CNT_W) + 1);
    localparam logic [LEN_W-1:0]  LEN_ONE = LEN_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t            state_q;
    logic [7:0]        cur_q;
    logic [LEN_W-1:0]  len_q;
    logic [63:0]       code_out_q;
    logic [6:0]        code_bits_q;
    logic              code_valid_q;
    logic              msg_fin_q;

    logic              accept;
    logic              same_byte;
    logic              run_full;
    logic [63:0]       pend_code_d;
    logic [6:0]        pend_bits_d;
    logic [LEN_W-1:0]  len_inc_d;

    // Literal for a lone byte, otherwise a run token carrying (len - 2) above the byte
    function automatic logic [63:0] run_code(input logic [7:0] b, input logic [LEN_W-1:0] l);
        logic [CNT_W-1:0] field;
        field = CNT_W'(l - LEN_W'(2));
        if (l == LEN_ONE) begin
            run_code = 64'({b, 1'b0});
        end else begin
            run_code = 64'({field, b, 1'b1});
        end
    endfunction

    function automatic logic [6:0] run_bits(input logic [LEN_W-1:0] l);
        if (l == LEN_ONE) begin
            run_bits = 7'd9;
        end else begin
            run_bits = 7'(9 + CNT_W);
        end
    endfunction

    assign byte_ready  = !rst && ((state_q == S_IDLE) || (state_q == S_RUN));
    assign accept      = byte_valid && byte_ready;
    assign same_byte   = (byte_in == cur_q);
    assign run_full    = (len_q == MAXRUN);
    assign pend_code_d = run_code(cur_q, len_q);
    assign pend_bits_d = run_bits(len_q);
    assign len_inc_d   = len_q + LEN_ONE;

    assign code_out    = code_out_q;
    assign code_bits   = code_bits_q;
    assign code_valid  = code_valid_q;
    assign msg_fin     = msg_fin_q;

    // Message FSM: tracks the pending run and registers every emitted code and the finish pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cur_q        <= '0;
            len_q        <= '0;
            code_out_q   <= '0;
            code_bits_q  <= '0;
            code_valid_q <= 1'b0;
            msg_fin_q    <= 1'b0;
        end else begin
            // Outputs are single-cycle pulses; idle cycles present all-zero code fields
            code_out_q   <= '0;
            code_bits_q  <= '0;
            code_valid_q <= 1'b0;
            msg_fin_q    <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        cur_q   <= byte_in;
                        len_q   <= LEN_ONE;
                        state_q <= byte_last ? S_FLUSH : S_RUN;
                    end
                end

                S_RUN: begin
                    if (accept) begin
                        if (same_byte && !run_full) begin
                            len_q <= len_inc_d;
                        end else begin
                            // Either the byte changed or the run hit its longest encodable length
                            code_out_q   <= pend_code_d;
                            code_bits_q  <= pend_bits_d;
                            code_valid_q <= 1'b1;
                            cur_q        <= byte_in;
                            len_q        <= LEN_ONE;
                        end
                        state_q <= byte_last ? S_FLUSH : S_RUN;
                    end
                end

                S_FLUSH: begin
                    code_out_q   <= pend_code_d;
                    code_bits_q  <= pend_bits_d;
                    code_valid_q <= 1'b1;
                    state_q      <= S_FIN;
                end

                S_FIN: begin
                    msg_fin_q <= 1'b1;
                    cur_q     <= '0;
                    len_q     <= '0;
                    state_q   <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/rle_encoder.md
RLE_ENCODER -- requirements
Module: rle_encoder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and rst.
REQ-002 The block SHALL have parameter CNT_W, default 6, giving the run-count field width; legal range is 1..8.
REQ-003 Port clk SHALL be an input, 1 bit wide: the system clock; all state updates on its rising edge.
REQ-004 Port rst SHALL be an input, 1 bit wide: synchronous active-high reset.
REQ-005 Port byte_in SHALL be an input, 8 bits wide: the uncompressed message byte.
REQ-006 Port byte_valid SHALL be an input, 1 bit wide: byte_in is valid this cycle.
REQ-007 Port byte_last SHALL be an input, 1 bit wide: byte_in is the final byte of the message; qualified by byte_valid.
REQ-008 Port byte_ready SHALL be an output, 1 bit wide: the encoder accepts a byte this cycle.
REQ-009 Port code_out SHALL be an output, 64 bits wide: the variable-length code, LSB-aligned, LSB first in time; unused bits are 0.
REQ-010 Port code_bits SHALL be an output, 7 bits wide: the number of valid bits in code_out.
REQ-011 Port code_valid SHALL be an output, 1 bit wide: code_out and code_bits are valid; one-cycle pulse per code.
REQ-012 Port msg_fin SHALL be an output, 1 bit wide: one-cycle pulse; the message is fully emitted and downstream flushes its partial word.

Function
REQ-013 A byte SHALL be accepted on a rising edge when byte_valid and byte_ready are both 1; byte_valid with byte_ready=0 is ignored (no buffering).
REQ-014 The FSM SHALL have states IDLE (nothing pending), RUN (byte cur and count len pending), FLUSH and FIN; byte_ready=1 only in IDLE and RUN with rst=0.
REQ-015 A run of length 1 SHALL be encoded as a literal: code_out = {byte, 1'b0}, code_bits = 9.
REQ-016 A run of length L in 2..MAXRUN (MAXRUN = 2^CNT_W + 1) SHALL be encoded as {L-2 [CNT_W-1:0], byte, 1'b1}, code_bits = 9 + CNT_W (15 at default).
REQ-017 In IDLE, an accepted byte SHALL load cur=byte, len=1, and move the FSM to RUN; no code is emitted.
REQ-018 In RUN, an accepted byte equal to cur with len < MAXRUN SHALL increment len; no code is emitted.
REQ-019 In RUN, an accepted byte equal to cur with len = MAXRUN SHALL emit the MAXRUN run code and set len=1.
REQ-020 In RUN, an accepted byte not equal to cur SHALL emit the code for (cur, len), then set cur=byte and len=1.
REQ-021 Code outputs SHALL be registered: code_valid rises in the cycle after the accepting edge; at most one code is emitted per cycle.
REQ-022 An accepted byte with byte_last=1 SHALL apply REQ-017..REQ-020 and then move the FSM to FLUSH.
REQ-023 FLUSH SHALL last exactly 1 cycle and emit the pending (cur, len) code, which appears on the outputs in the following cycle; the FSM then moves to FIN.
REQ-024 FIN SHALL last exactly 1 cycle: msg_fin pulses high the cycle after the last code_valid, pending state clears, and the FSM returns to IDLE.
REQ-025 A one-byte message (IDLE + byte_last) SHALL produce exactly one literal followed by msg_fin.
REQ-026 When code_valid=0, code_out and code_bits SHALL be 0.
REQ-027 The block SHALL ignore downstream backpressure, since downstream accepts every code_valid cycle.

Reset
REQ-028 With rst=1 at a rising edge, the FSM SHALL go to IDLE, clear cur and len, and drive code_out=0, code_bits=0, code_valid=0 and msg_fin=0 from the next cycle.
REQ-029 byte_ready SHALL be 0 while rst=1.
REQ-030 A reset mid-run or mid-FLUSH SHALL discard the pending run with no partial code and no msg_fin emitted.
REQ-031 rst SHALL have priority over every other input.

Verification
REQ-032 Bench SHALL cover: bytes 0x41, 0x42 (last) -> codes 0x082/9 then 0x084/9, then msg_fin the next cycle.
REQ-033 Bench SHALL cover: bytes 0x55 x3 (last on third) -> single code 0x2AB/15, then msg_fin.
REQ-034 Bench SHALL cover: 66 x 0x00 (last on 66th) -> 0x7E01/15 (run of 65), then literal 0x000/9, then msg_fin.
REQ-035 Bench SHALL cover: single byte 0xFF with last -> 0x1FE/9 in cycle N+1 and msg_fin in cycle N+2; byte_ready=0 during FLUSH and FIN, and byte_valid in those cycles is dropped.
REQ-036 Bench SHALL cover: bytes 0x33 x4, rst on the next edge -> no code_valid, no msg_fin; next message 0x10 (last) -> 0x020/9 only.
REQ-037 Bench SHALL cover: back-to-back messages with byte_valid held high -> no byte accepted in FLUSH or FIN, and the second message's codes are unaffected.
